// File: rtl/button_debouncer_pkg.sv
// Shared types and width helpers for the multi-channel button debouncer.
// Imported by the channel cell and the top level.
package button_debouncer_pkg;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_SETTLING = 1'b1
  } ch_state_e;

  // Width of a counter that must be able to hold the value stable_ticks.
  function automatic int cnt_width(input int stable_ticks);
    return $clog2(stable_ticks + 1);
  endfunction

  // Width of the prescaler; at least one bit even when it never leaves 0.
  function automatic int presc_width(input int tick_div);
    return (tick_div > 1) ? $clog2(tick_div) : 1;
  endfunction

endpackage

// File: rtl/button_debouncer_debounce_cell.sv
// One debounce channel: input synchronizer, STABLE/SETTLING state machine,
// settle tick counter and registered rise/fall strobes.
module debounce_cell
  import button_debouncer_pkg::*;
#(
  parameter int   SYNC_STAGES  = 2,
  parameter int   STABLE_TICKS = 20,
  parameter logic RESET_LEVEL  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  input  logic tick,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int                CNT_W    = cnt_width(STABLE_TICKS);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_bit;
  ch_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  assign sync_bit = sync_q[SYNC_STAGES-1];

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values and the synchronizer shifts one stage per clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      level_q <= RESET_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_in};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      ST_STABLE: begin
        if (sync_bit != level_q) begin
          state_d = ST_SETTLING;
          cnt_d   = '0;
        end
      end
      ST_SETTLING: begin
        // A bounce back to the accepted level wins over a coincident tick.
        if (sync_bit == level_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_q == CNT_LAST) begin
            level_d = ~level_q;
            rise_d  = ~level_q;
            fall_d  = level_q;
            cnt_d   = '0;
            state_d = ST_STABLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign level_out  = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel button debouncer: one shared sample-tick prescaler feeding
// NUM_CH independent debounce cells.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int                NUM_CH       = 4,
  parameter int                SYNC_STAGES  = 2,
  parameter int                TICK_DIV     = 50000,
  parameter int                STABLE_TICKS = 20,
  parameter logic [NUM_CH-1:0] RESET_LEVEL  = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] raw_in,
  output logic [NUM_CH-1:0] level_out,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] fall_pulse
);

  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("button_debouncer: SYNC_STAGES must be >= 2");
  end
  if (TICK_DIV < 1) begin : g_bad_tick_div
    $error("button_debouncer: TICK_DIV must be >= 1");
  end
  if (STABLE_TICKS < 1) begin : g_bad_stable_ticks
    $error("button_debouncer: STABLE_TICKS must be >= 1");
  end

  localparam int                  PRESC_W    = presc_width(TICK_DIV);
  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               tick;

  // With TICK_DIV=1 the count is pinned at 0 and tick is high every cycle.
  assign tick = (presc_q == PRESC_LAST);

  always_comb begin
    presc_d = tick ? '0 : presc_q + PRESC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_cell #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_TICKS (STABLE_TICKS),
      .RESET_LEVEL  (RESET_LEVEL[i])
    ) u_cell (
      .clk        (clk),
      .rst        (rst),
      .raw_in     (raw_in[i]),
      .tick       (tick),
      .level_out  (level_out[i]),
      .rise_pulse (rise_pulse[i]),
      .fall_pulse (fall_pulse[i])
    );
  end

endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent input channels.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer flop depth, minimum 2.
REQ-003 SHALL have parameter TICK_DIV, default 50000: clk cycles per sample tick (1 ms at 50 MHz), minimum 1.
REQ-004 SHALL have parameter STABLE_TICKS, default 20: consecutive ticks an input must differ from the debounced level before the level is accepted, minimum 1.
REQ-005 SHALL have parameter RESET_LEVEL, default all-ones, width NUM_CH: idle level per channel (pushbuttons idle high).
REQ-006 SHALL have port clk, input, 1 bit: single clock; all logic is synchronous to its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-008 SHALL have port raw_in, input, NUM_CH bits: asynchronous, bouncing button/switch inputs.
REQ-009 SHALL have port level_out, output, NUM_CH bits: debounced level; drives downstream edge-detect stages.
REQ-010 SHALL have port rise_pulse, output, NUM_CH bits: one-cycle strobe when level_out goes 0->1.
REQ-011 SHALL have port fall_pulse, output, NUM_CH bits: one-cycle strobe when level_out goes 1->0.

Function
REQ-012 SHALL pass each raw_in bit through a SYNC_STAGES-deep flop chain; the last stage is sync[i].
REQ-013 SHALL run one shared prescaler that counts 0..TICK_DIV-1 and wraps to 0; tick is high for exactly the one cycle the count equals TICK_DIV-1 (tick high every cycle when TICK_DIV=1).
REQ-014 SHALL hold per-channel state STABLE or SETTLING and a tick counter of width $clog2(STABLE_TICKS+1).
REQ-015 In STABLE, when sync[i] != level_out[i], SHALL move to SETTLING with counter 0 on the next edge.
REQ-016 In SETTLING, when sync[i] == level_out[i], SHALL return to STABLE with counter 0; this takes priority over a coincident tick.
REQ-017 In SETTLING, when sync[i] != level_out[i] and tick is high, SHALL increment the counter. When the increment would reach STABLE_TICKS, it SHALL instead invert level_out[i], clear the counter and return to STABLE, all on that edge.
REQ-018 SHALL assert rise_pulse[i] or fall_pulse[i] for exactly the one cycle following the edge at which level_out[i] changed; both SHALL never be high together on one channel.
REQ-019 SHALL update level_out[i] between SYNC_STAGES+(STABLE_TICKS-1)*TICK_DIV+1 and SYNC_STAGES+STABLE_TICKS*TICK_DIV cycles after a clean raw_in[i] transition.
REQ-020 SHALL ignore any glitch that is shorter than STABLE_TICKS-1 full tick periods: no level change and no strobe.
REQ-021 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own strobes in the same cycle.

Reset
REQ-022 While rst is high, SHALL set level_out=RESET_LEVEL, rise_pulse=0, fall_pulse=0, prescaler=0, all states STABLE, all counters 0.
REQ-023 While rst is high, SHALL preset every synchronizer stage to RESET_LEVEL, so that no strobe is produced after reset release when raw_in equals RESET_LEVEL.
REQ-024 Reset asserted during SETTLING SHALL abort the settle with no level change and no strobe.

Structure
REQ-025 SHALL place the channel state enum (STABLE, SETTLING) and the counter-width helper constants in package button_debouncer_pkg.
REQ-026 SHALL implement one channel as sub-module debounce_cell (synchronizer, state, counter, strobes), instantiated NUM_CH times; the prescaler SHALL live in the top level only.
REQ-027 SHALL check the parameter minimums (SYNC_STAGES>=2, TICK_DIV>=1, STABLE_TICKS>=1) at elaboration.

Verification
REQ-028 Bench SHALL use NUM_CH=2, SYNC_STAGES=2, TICK_DIV=4, STABLE_TICKS=3, RESET_LEVEL=2'b11.
REQ-029 Reset release with raw_in=11 -> level_out=11, no strobes for 50 cycles.
REQ-030 raw_in[0] 1->0 held clean -> level_out[0]=0 within 11..14 cycles, with fall_pulse[0] high for exactly 1 cycle.
REQ-031 raw_in[0] low pulse of 5 cycles -> level_out[0] stays 1, no strobes.
REQ-032 raw_in 11->00 in the same cycle -> fall_pulse=11 in the same single cycle.
REQ-033 rst asserted 8 cycles into a settle -> level_out=RESET_LEVEL, no strobe; after release, a held-low input settles again per REQ-030.
REQ-034 Channel 1 bouncing 0/1 every 3 cycles for 40 cycles, then held at 0 -> exactly one fall_pulse[1], occurring within 11..14 cycles of the final edge.
